// File: rtl/axi4_burst_operand_master.sv
// AXI4 master: writes NOPS operands as DSZ-wide bursts to slave addresses 0..NOPS-1,
// then reads one RSZ-bit result burst from RES_ADDR. All outputs are registered.
module axi4_burst_operand_master #(
    parameter int unsigned SZ       = 32,
    parameter int unsigned DSZ      = 8,
    parameter int unsigned ASZ      = 2,
    parameter int unsigned NOPS     = 2,
    parameter int unsigned RSZ      = 2 * SZ,
    parameter int unsigned RES_ADDR = 0
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic                i_cont,
    input  logic [NOPS*SZ-1:0]  i_ops,
    output logic [RSZ-1:0]      o_res,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_err,
    output logic [ASZ-1:0]      o_awaddr,
    output logic                o_awvalid,
    input  logic                i_awready,
    output logic [DSZ-1:0]      o_wdata,
    output logic                o_wvalid,
    input  logic                i_wready,
    output logic                o_wlast,
    input  logic                i_bresp,
    input  logic                i_bvalid,
    output logic                o_bready,
    output logic [ASZ-1:0]      o_araddr,
    output logic                o_arvalid,
    input  logic                i_arready,
    input  logic [DSZ-1:0]      i_rdata,
    input  logic                i_rvalid,
    output logic                o_rready,
    input  logic                i_rlast,
    input  logic                i_rresp
);
    localparam int unsigned BEATS  = SZ / DSZ;
    localparam int unsigned RBEATS = RSZ / DSZ;
    localparam int unsigned WPW    = $clog2(BEATS + 1);
    localparam int unsigned RPW    = $clog2(RBEATS + 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_AW   = 3'd1;
    localparam logic [2:0] S_W    = 3'd2;
    localparam logic [2:0] S_B    = 3'd3;
    localparam logic [2:0] S_AR   = 3'd4;
    localparam logic [2:0] S_R    = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    logic [2:0]         r_state,   w_state;
    logic [NOPS*SZ-1:0] r_ops,     w_ops;
    logic [ASZ-1:0]     r_opk,     w_opk;
    logic [WPW-1:0]     r_wpos,    w_wpos;
    logic [SZ-1:0]      r_wsh,     w_wsh;
    logic [RPW-1:0]     r_rpos,    w_rpos;
    logic [RSZ-1:0]     r_res,     w_res;
    logic               r_err,     w_err;
    logic               r_busy,    w_busy;
    logic               r_done,    w_done;
    logic [ASZ-1:0]     r_awaddr,  w_awaddr;
    logic               r_awvalid, w_awvalid;
    logic [DSZ-1:0]     r_wdata,   w_wdata;
    logic               r_wvalid,  w_wvalid;
    logic               r_wlast,   w_wlast;
    logic               r_bready,  w_bready;
    logic [ASZ-1:0]     r_araddr,  w_araddr;
    logic               r_arvalid, w_arvalid;
    logic               r_rready,  w_rready;
    logic [SZ-1:0]      w_cur_op;

    // Next-state and next-output logic; every register defaults to holding its value.
    always_comb begin
        w_state   = r_state;
        w_ops     = r_ops;
        w_opk     = r_opk;
        w_wpos    = r_wpos;
        w_wsh     = r_wsh;
        w_rpos    = r_rpos;
        w_res     = r_res;
        w_err     = r_err;
        w_busy    = r_busy;
        w_done    = 1'b0;
        w_awaddr  = r_awaddr;
        w_awvalid = r_awvalid;
        w_wdata   = r_wdata;
        w_wvalid  = r_wvalid;
        w_wlast   = r_wlast;
        w_bready  = r_bready;
        w_araddr  = r_araddr;
        w_arvalid = r_arvalid;
        w_rready  = r_rready;
        w_cur_op  = '0;
        for (int k = 0; k < NOPS; k++) begin
            if (r_opk == ASZ'(k)) w_cur_op = r_ops[k*SZ +: SZ];
        end

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_ops     = i_ops;
                    w_res     = '0;
                    w_err     = 1'b0;
                    w_opk     = '0;
                    w_awaddr  = '0;
                    w_awvalid = 1'b1;
                    w_busy    = 1'b1;
                    w_state   = S_AW;
                end
            end
            S_AW: begin
                if (i_awready) begin
                    w_awvalid = 1'b0;
                    w_wpos    = '0;
                    w_wdata   = w_cur_op[DSZ-1:0];
                    w_wsh     = w_cur_op >> DSZ;
                    w_wvalid  = 1'b1;
                    w_wlast   = (BEATS == 1);
                    w_state   = S_W;
                end
            end
            S_W: begin
                if (i_wready) begin
                    if (r_wlast) begin
                        w_wvalid = 1'b0;
                        w_wlast  = 1'b0;
                        w_wdata  = '0;
                        w_bready = 1'b1;
                        w_state  = S_B;
                    end else begin
                        w_wpos  = r_wpos + WPW'(1);
                        w_wdata = r_wsh[DSZ-1:0];
                        w_wsh   = r_wsh >> DSZ;
                        w_wlast = (w_wpos == WPW'(BEATS - 1));
                    end
                end
            end
            S_B: begin
                if (i_bvalid && r_bready) begin
                    w_bready = 1'b0;
                    if (!i_bresp) w_err = 1'b1;
                    if (r_opk < ASZ'(NOPS - 1)) begin
                        w_opk     = r_opk + ASZ'(1);
                        w_awaddr  = w_opk;
                        w_awvalid = 1'b1;
                        w_state   = S_AW;
                    end else begin
                        w_araddr  = ASZ'(RES_ADDR);
                        w_arvalid = 1'b1;
                        w_state   = S_AR;
                    end
                end
            end
            S_AR: begin
                if (i_arready) begin
                    w_arvalid = 1'b0;
                    w_rpos    = '0;
                    w_rready  = 1'b1;
                    w_state   = S_R;
                end
            end
            S_R: begin
                if (i_rvalid && r_rready) begin
                    // Beats beyond the result width are dropped and flagged.
                    if (r_rpos < RPW'(RBEATS)) begin
                        for (int b = 0; b < RBEATS; b++) begin
                            if (r_rpos == RPW'(b)) w_res[b*DSZ +: DSZ] = i_rdata;
                        end
                        w_rpos = r_rpos + RPW'(1);
                    end else begin
                        w_err = 1'b1;
                    end
                    if (!i_rresp) w_err = 1'b1;
                    if (i_rlast) begin
                        if (r_rpos < RPW'(RBEATS - 1)) w_err = 1'b1;
                        w_rready = 1'b0;
                        w_done   = 1'b1;
                        w_state  = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (i_cont) begin
                    w_ops     = i_ops;
                    w_res     = '0;
                    w_err     = 1'b0;
                    w_opk     = '0;
                    w_awaddr  = '0;
                    w_awvalid = 1'b1;
                    w_state   = S_AW;
                end else begin
                    w_busy  = 1'b0;
                    w_state = S_IDLE;
                end
            end
            default: begin
                w_state = S_IDLE;
                w_busy  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_ops     <= '0;
            r_opk     <= '0;
            r_wpos    <= '0;
            r_wsh     <= '0;
            r_rpos    <= '0;
            r_res     <= '0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_awaddr  <= '0;
            r_awvalid <= 1'b0;
            r_wdata   <= '0;
            r_wvalid  <= 1'b0;
            r_wlast   <= 1'b0;
            r_bready  <= 1'b0;
            r_araddr  <= '0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_ops     <= w_ops;
            r_opk     <= w_opk;
            r_wpos    <= w_wpos;
            r_wsh     <= w_wsh;
            r_rpos    <= w_rpos;
            r_res     <= w_res;
            r_err     <= w_err;
            r_busy    <= w_busy;
            r_done    <= w_done;
            r_awaddr  <= w_awaddr;
            r_awvalid <= w_awvalid;
            r_wdata   <= w_wdata;
            r_wvalid  <= w_wvalid;
            r_wlast   <= w_wlast;
            r_bready  <= w_bready;
            r_araddr  <= w_araddr;
            r_arvalid <= w_arvalid;
            r_rready  <= w_rready;
        end
    end

    assign o_res     = r_res;
    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_err     = r_err;
    assign o_awaddr  = r_awaddr;
    assign o_awvalid = r_awvalid;
    assign o_wdata   = r_wdata;
    assign o_wvalid  = r_wvalid;
    assign o_wlast   = r_wlast;
    assign o_bready  = r_bready;
    assign o_araddr  = r_araddr;
    assign o_arvalid = r_arvalid;
    assign o_rready  = r_rready;

endmodule

// File: tb/tb_axi4_burst_operand_master.sv
// Bench for axi4_burst_operand_master: a cycle-stepped AXI slave with configurable
// stalls and faults, checked against a transaction-level model of writes, result and timing.
module tb_axi4_burst_operand_master;
    localparam int SZ     = 32;
    localparam int DSZ    = 8;
    localparam int ASZ    = 2;
    localparam int NOPS   = 2;
    localparam int RSZ    = 64;
    localparam int BEATS  = SZ / DSZ;
    localparam int RBEATS = RSZ / DSZ;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               i_start, i_cont;
    logic [NOPS*SZ-1:0] i_ops;
    logic [RSZ-1:0]     o_res;
    logic               o_busy, o_done, o_err;
    logic [ASZ-1:0]     o_awaddr, o_araddr;
    logic               o_awvalid, i_awready;
    logic [DSZ-1:0]     o_wdata, i_rdata;
    logic               o_wvalid, i_wready, o_wlast;
    logic               i_bresp, i_bvalid, o_bready;
    logic               o_arvalid, i_arready;
    logic               i_rvalid, o_rready, i_rlast, i_rresp;

    axi4_burst_operand_master dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_cont(i_cont), .i_ops(i_ops),
        .o_res(o_res), .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
        .o_awaddr(o_awaddr), .o_awvalid(o_awvalid), .i_awready(i_awready),
        .o_wdata(o_wdata), .o_wvalid(o_wvalid), .i_wready(i_wready), .o_wlast(o_wlast),
        .i_bresp(i_bresp), .i_bvalid(i_bvalid), .o_bready(o_bready),
        .o_araddr(o_araddr), .o_arvalid(o_arvalid), .i_arready(i_arready),
        .i_rdata(i_rdata), .i_rvalid(i_rvalid), .o_rready(o_rready),
        .i_rlast(i_rlast), .i_rresp(i_rresp)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Slave configuration for the next transaction
    int aw_st, w_st, b_st, ar_st, r_st;
    int rlen, bad_b_op, bad_r_beat, mid_start_e, abort_wbeat;
    bit drop_cont;
    logic [7:0] rbytes [16];
    logic [NOPS*SZ-1:0] exp_ops;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_slave();
        i_awready = 1'b0; i_wready = 1'b0; i_bvalid = 1'b0; i_bresp = 1'b1;
        i_arready = 1'b0; i_rvalid = 1'b0; i_rlast = 1'b0; i_rresp = 1'b1; i_rdata = '0;
    endtask

    task automatic set_defaults();
        aw_st = 0; w_st = 0; b_st = 0; ar_st = 0; r_st = 0;
        rlen = RBEATS; bad_b_op = -1; bad_r_beat = -1; mid_start_e = -1; abort_wbeat = -1;
        drop_cont = 1'b0;
        for (int i = 0; i < 16; i++) rbytes[i] = 8'h00;
    endtask

    task automatic random_rbytes();
        for (int i = 0; i < 16; i++) rbytes[i] = 8'($urandom);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_res"}, o_res, 64'h0);
        check_eq({tag, "_ctl"}, {o_busy, o_done, o_err, o_awvalid, o_wvalid, o_wlast, o_bready,
                                 o_arvalid, o_rready, o_awaddr, o_araddr, o_wdata}, 64'h0);
    endtask

    task automatic idle_check();
        @(posedge clk);
        @(negedge clk);
        check_eq("done_pulse_end", o_done, 1'b0);
        check_eq("idle_busy", o_busy, 1'b0);
    endtask

    // Steps one transaction from the edge where start (or cont) is sampled up to done.
    task automatic run_txn();
        int e = -1;
        int wk = 0, wi = 0, ri = 0;
        int aw_c = 0, w_c = 0, b_c = 0, ar_c = 0, r_c = 0;
        bit p_aw = 0, p_w = 0, p_ar = 0, fin = 0;
        logic [ASZ-1:0] pa = '0, par = '0;
        logic [DSZ-1:0] pw = '0;
        logic pl = 1'b0;
        logic [RSZ-1:0] eres = '0;
        bit eerr;
        int edone;
        for (int i = 0; i < rlen && i < RBEATS; i++) eres[i*DSZ +: DSZ] = rbytes[i];
        eerr = (bad_b_op >= 0 && bad_b_op < NOPS) || (bad_r_beat >= 0 && bad_r_beat < rlen)
               || (rlen != RBEATS);
        edone = NOPS * (BEATS + 2) + rlen + 2
              + NOPS * (aw_st + BEATS * w_st + b_st) + ar_st + rlen * r_st;
        while (!fin) begin
            @(posedge clk);
            e++;
            @(negedge clk);
            if (e == 0) begin
                i_start = 1'b0;
                if (drop_cont) i_cont = 1'b0;
                check_eq("capture_err", o_err, 1'b0);
                check_eq("capture_res", o_res, 64'h0);
                check_eq("done_low", o_done, 1'b0);
            end
            if (e == mid_start_e) begin
                i_start = 1'b1;
                i_ops = ~exp_ops;
            end else if (e == mid_start_e + 1) begin
                i_start = 1'b0;
            end
            if (p_aw) check_eq("aw_hold", {o_awvalid, o_awaddr}, {1'b1, pa});
            if (p_w)  check_eq("w_hold", {o_wvalid, o_wlast, o_wdata}, {1'b1, pl, pw});
            if (p_ar) check_eq("ar_hold", {o_arvalid, o_araddr}, {1'b1, par});
            check_eq("one_valid", $countones({o_awvalid, o_wvalid, o_arvalid}) <= 1, 1'b1);
            check_eq("busy", o_busy, 1'b1);
            if (abort_wbeat >= 0 && o_wvalid && wi == abort_wbeat) begin
                clear_slave();
                rst_n = 1'b0;
                return;
            end
            clear_slave();
            p_aw = 0; p_w = 0; p_ar = 0;
            if (o_awvalid) begin
                if (aw_c >= aw_st) begin
                    i_awready = 1'b1; aw_c = 0;
                    check_eq("awaddr", o_awaddr, wk);
                end else begin
                    aw_c++; p_aw = 1; pa = o_awaddr;
                end
            end
            if (o_wvalid) begin
                if (w_c >= w_st) begin
                    i_wready = 1'b1; w_c = 0;
                    check_eq("wdata", o_wdata, exp_ops[wk*SZ + wi*DSZ +: DSZ]);
                    check_eq("wlast", o_wlast, wi == BEATS - 1);
                    wi++;
                end else begin
                    w_c++; p_w = 1; pw = o_wdata; pl = o_wlast;
                end
            end
            if (o_bready) begin
                if (b_c >= b_st) begin
                    i_bvalid = 1'b1; b_c = 0;
                    i_bresp = (wk != bad_b_op);
                    check_eq("b_after_burst", wi, BEATS);
                    wi = 0; wk++;
                end else begin
                    b_c++;
                end
            end
            if (o_arvalid) begin
                if (ar_c >= ar_st) begin
                    i_arready = 1'b1; ar_c = 0;
                    check_eq("araddr", o_araddr, 0);
                    check_eq("ar_after_writes", wk, NOPS);
                end else begin
                    ar_c++; p_ar = 1; par = o_araddr;
                end
            end
            if (o_rready) begin
                if (r_c >= r_st) begin
                    i_rvalid = 1'b1; r_c = 0;
                    i_rdata = (ri < 16) ? rbytes[ri] : 8'h00;
                    i_rlast = (ri == rlen - 1);
                    i_rresp = (ri != bad_r_beat);
                    ri++;
                end else begin
                    r_c++;
                end
            end
            if (o_done) begin
                check_eq("done_edge", e + 1, edone);
                check_eq("res", o_res, eres);
                check_eq("err", o_err, eerr);
                check_eq("r_beats", ri, rlen);
                fin = 1;
            end
            if (!fin && e > 3000) begin
                check_eq("timeout", e, edone);
                fin = 1;
            end
        end
    endtask

    task automatic start_txn(input logic [NOPS*SZ-1:0] ops);
        i_ops = ops;
        exp_ops = ops;
        i_start = 1'b1;
        run_txn();
    endtask

    initial begin
        logic [NOPS*SZ-1:0] ops_b;
        rst_n = 1'b0; i_start = 1'b0; i_cont = 1'b0; i_ops = '0;
        clear_slave();
        set_defaults();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Ideal slave, known operands and result
        rbytes[0] = 8'h0F;
        start_txn({32'h0000_0003, 32'h0000_0005});
        idle_check();

        // Back-pressure on every channel
        aw_st = 3; w_st = 3; ar_st = 3; b_st = 2;
        start_txn({32'h0000_0003, 32'h0000_0005});
        idle_check();

        // Error responses, then a clean transaction clears err
        set_defaults(); random_rbytes();
        bad_b_op = 1; bad_r_beat = 3;
        start_txn({$urandom, $urandom});
        idle_check();
        set_defaults(); random_rbytes();
        start_txn({$urandom, $urandom});
        idle_check();

        // Short and long read bursts
        set_defaults(); random_rbytes(); rlen = 5;
        start_txn({$urandom, $urandom});
        check_eq("short_upper_zero", o_res[63:40], 24'h0);
        idle_check();
        set_defaults(); random_rbytes(); rlen = 10;
        start_txn({$urandom, $urandom});
        idle_check();

        // Continuous mode with an ignored mid-transaction start
        set_defaults(); random_rbytes();
        i_cont = 1'b1; mid_start_e = 5;
        start_txn({$urandom, $urandom});
        ops_b = {$urandom, $urandom};
        i_ops = ops_b; exp_ops = ops_b;
        mid_start_e = -1; drop_cont = 1'b1; random_rbytes();
        run_txn();
        idle_check();

        // Reset while beat 2 of the first burst is presented
        set_defaults();
        abort_wbeat = 2;
        start_txn({$urandom, $urandom});
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("mid_reset");
        rst_n = 1'b1;
        set_defaults(); random_rbytes();
        start_txn({$urandom, $urandom});
        idle_check();

        // Randomized stalls, data, faults and burst lengths
        for (int it = 0; it < 8; it++) begin
            int sel;
            set_defaults(); random_rbytes();
            aw_st = int'($urandom_range(0, 3)); w_st = int'($urandom_range(0, 2));
            b_st = int'($urandom_range(0, 3)); ar_st = int'($urandom_range(0, 3));
            r_st = int'($urandom_range(0, 2));
            bad_b_op = int'($urandom_range(0, 3)); bad_r_beat = int'($urandom_range(0, 15));
            sel = int'($urandom_range(0, 3));
            rlen = (sel == 0) ? 6 : (sel == 1) ? 9 : RBEATS;
            start_txn({$urandom, $urandom});
            idle_check();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/axi4_burst_operand_master.md
# axi4_burst_operand_master

- Parametrised AXI4 master that reads NOPS operands of SZ bits each and writes each one as its own DSZ-wide write burst to consecutive slave addresses.
- After the last write response it issues one read burst and collects an RSZ-bit result.
- It sits between a compute front end (start/done handshake) and an AXI4 arithmetic peripheral.
- Compared with the previous master it adds: configurable widths and operand count, response-error reporting, an explicit transaction FSM and a continuous mode.

## Interface
Parameters:
- SZ, 32, operand width; must be a multiple of DSZ
- DSZ, 8, AXI data beat width
- ASZ, 2, AXI address width; 2^ASZ > NOPS
- NOPS, 2, number of operands, 1..2^ASZ-1
- RSZ, 2*SZ, result width; multiple of DSZ
- RES_ADDR, 0, read address of the result burst
- Derived: BEATS = SZ/DSZ; RBEATS = RSZ/DSZ

Ports (clock and reset first):
- clk  in  1  clock
- _rst  in  1  synchronous, active-low reset
- start  in  1  begin a transaction; sampled only in IDLE
- cont  in  1  continuous mode; sampled in DONE
- ops  in  NOPS*SZ  operand k is ops[k*SZ +: SZ]; captured when start is accepted
- res  out  RSZ  result register
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at transaction end
- err  out  1  sticky error for the current transaction
- awaddr/awvalid/awready, wdata/wvalid/wready/wlast, bresp/bvalid/bready: AXI write channels, standard directions; bresp is 1 bit, 1 = ok
- araddr/arvalid/arready, rdata/rvalid/rready/rlast, rresp: AXI read channels; rresp is 1 bit, 1 = ok

## Operation
FSM states: IDLE, AW, W, B, AR, R, DONE.
- **IDLE:**
  - start=1: capture ops into the operand register, clear res to 0, clear err, set opk=0, then go to AW.
  - start while busy is ignored.
- **AW:**
  - Drives awvalid=1 and awaddr=opk. awvalid is held until awready.
  - On handshake: go to W with wpos=0, wdata = beat 0, wvalid=1, and wlast=(BEATS==1).
- **W:**
  - Beat i is operand[opk][i*DSZ +: DSZ], LSB first.
  - Each handshake advances wpos and loads the next beat. wlast is high exactly on beat BEATS-1.
  - The handshake on the wlast beat drops wvalid and wlast, sets wdata to 0, and goes to B.
- **B:**
  - bready=1.
  - On handshake: if bresp==0, set err.
  - Then, if opk<NOPS-1: opk+1 and go to AW. Otherwise go to AR.
- **AR:**
  - arvalid=1 and araddr=RES_ADDR, held until arready.
  - On handshake: rpos=0, then go to R.
- **R:**
  - rready=1.
  - On each handshake:
    - If rpos<RBEATS: res[rpos*DSZ +: DSZ] = rdata.
    - Otherwise discard the beat and set err.
    - If rresp==0, set err.
    - Increment rpos, saturating at RBEATS.
  - On a handshake with rlast: if fewer than RBEATS beats were received, set err (unreceived result beats stay 0). Then go to DONE.
- **DONE:**
  - done=1 for exactly one cycle.
  - If cont=1: re-capture ops, clear res and err, and go to AW (busy stays 1).
  - Otherwise go to IDLE.
- Between transactions, res and err hold their values until the next capture.
- Only one AXI valid is asserted at a time. Write and read channels are never concurrent.

## Timing
- **Reset** (_rst=0 at a clk edge) forces, on that edge:
  - state=IDLE, res=0, err=0, busy=0, done=0
  - all valid, ready and last signals = 0; awaddr=araddr=0; wdata=0
- Reset mid-transaction aborts immediately, with no completion of the outstanding burst.
- **Handshake rules:**
  - valid never depends combinationally on ready.
  - awaddr, araddr, wdata and wlast are stable while their valid is high without ready.
- **Latency** with a slave that keeps every ready, bvalid and rvalid high:
  - Start sampled at edge 0.
  - AW handshake at edge 1; W beats at edges 2..BEATS+1; B handshake at edge BEATS+2.
  - Each operand costs BEATS+2 cycles.
  - AR handshake at edge NOPS*(BEATS+2)+1; R beats follow, one per cycle.
  - done is high during the cycle after the final R handshake, i.e. sampled at edge NOPS*(BEATS+2)+RBEATS+2. For the defaults that is edge 22.
- Every wait state on a ready or valid input adds exactly one cycle.
- All outputs are registered.

## Test plan
- **Defaults, ideal slave, ops={b=0x0000_0003, a=0x0000_0005}, slave returns 0x0F,0,0,0,0,0,0,0:**
  - Write 1: awaddr 0, wdata 05,00,00,00, wlast on the 4th beat.
  - Write 2: awaddr 1, wdata 03,00,00,00.
  - Result: res=0x0F, err=0, done pulses at edge 22.
- **Back-pressure:** awready, wready and arready low for 3 cycles each time, bvalid delayed by 2 cycles.
  - awaddr, wdata and araddr are held stable throughout.
  - Same data as the first test; done is delayed by exactly the inserted cycles.
- **Error response:** bresp=0 on operand 1 and rresp=0 on beat 3.
  - err=1 at done; the transaction still completes.
  - err is cleared on the next start.
- **Short or long read bursts:**
  - rlast on beat 5: err=1 and res[63:40]=0.
  - 10 beats before rlast: err=1 and beats 9-10 are discarded.
- **Continuous mode and ignored start:** cont=1 throughout; start pulsed mid-transaction.
  - A second transaction begins immediately after the done pulse with re-captured ops.
  - The mid-transaction start is ignored.
- **Reset during the W burst on beat 2:** all outputs return to their reset values on that edge.
  - After reset, a new start gives a clean sequence beginning with awaddr 0.
